// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg
// Shared definitions for the loadable instruction memory:
//   DEFAULT_PROG  - 16-word program image that the memory holds after reset
//   DEFAULT_INSTR - word returned for fetches beyond the implemented depth
//   load_state_t  - program-loader FSM state encoding
//   default_word  - safe lookup into DEFAULT_PROG (zero beyond 16 entries)
package instr_mem_pkg;

  localparam int          PROG_WORDS    = 16;
  localparam logic [15:0] DEFAULT_INSTR = 16'h0032;

  localparam logic [15:0] DEFAULT_PROG [PROG_WORDS] = '{
    16'h0120, 16'h8111, 16'h8111, 16'h8222,
    16'h0230, 16'h4012, 16'h2103, 16'h8333,
    16'h0342, 16'hC104, 16'h1000, 16'h6215,
    16'h8444, 16'h0453, 16'hF000, 16'h0032
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  // Lets the memory depth exceed the stored image without indexing past it.
  function automatic logic [15:0] default_word(input int idx);
    if (idx < PROG_WORDS) return DEFAULT_PROG[idx];
    return 16'h0000;
  endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Program-loader FSM (IDLE -> LOAD -> DONE -> IDLE) for the instruction memory.
// Generates the write strobe and word address for sequential image loading.
// Only active when INSTR_MEM_LOAD_EN is defined; otherwise it parks in IDLE
// with every output inactive.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   load_start            - begin a load (honoured in IDLE only)
//   load_valid            - load word offered this cycle
//   state                 - current FSM state (debug / fetch gating)
//   load_ready            - loader accepts a word (decodes state only)
//   load_busy, load_done  - registered status; load_done is a one-cycle pulse
//   load_count            - words written in current/last load
//   we, waddr             - memory write strobe and word address
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  output load_state_t       state,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              we,
  output logic [ADDR_W-1:0] waddr
);

`ifdef INSTR_MEM_LOAD_EN

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

  load_state_t       state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              busy_q, done_q;
  logic              accept;

  assign load_ready = (state_q == LOAD);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST_WORD) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered copies of "next state is LOAD/DONE", so they
  // line up exactly with the state register without a combinational decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= (state_d == LOAD);
      done_q  <= (state_d == DONE);
    end
  end

  assign state      = state_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
  assign load_count = count_q;
  assign we         = accept;
  // The running count doubles as the write pointer.
  assign waddr      = count_q[ADDR_W-1:0];

`else

  logic unused_loader_inputs;
  assign unused_loader_inputs = ^{clk, rst, load_start, load_valid};

  assign state      = IDLE;
  assign load_ready = 1'b0;
  assign load_busy  = 1'b0;
  assign load_done  = 1'b0;
  assign load_count = '0;
  assign we         = 1'b0;
  assign waddr      = '0;

`endif

endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable
// Synchronous-read instruction memory with a reset-time default program and an
// optional sequential program loader (enabled by defining INSTR_MEM_LOAD_EN).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   fetch_req, fetch_addr    - fetch request and word address
//   fetch_ready              - fetch accepted this cycle when high (state decode)
//   instr, instr_valid       - fetched word, registered one cycle after accept
//   addr_err                 - completed fetch addressed beyond DEPTH
//   load_start               - begin a program load
//   load_valid, load_data    - load word and its qualifier
//   load_ready               - loader accepts a word (state decode)
//   load_busy, load_done     - load in progress / one-cycle completion pulse
//   load_count               - words written in current/last load
// Handshakes: a transfer happens on a rising edge where both the valid-side
// signal (fetch_req / load_valid) and the matching ready are high; valid may
// be asserted without waiting for ready, and ready depends only on FSM state.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int               DATA_W        = 16,
  parameter int               ADDR_W        = 4,
  parameter int               DEPTH         = 16,
  parameter logic [DATA_W-1:0] DEFAULT_INSTR = DATA_W'(instr_mem_pkg::DEFAULT_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  load_state_t       load_state;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              fetch_accept;
  logic              in_range;

  logic [DATA_W-1:0] mem [DEPTH];

  instr_mem_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .state      (load_state),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_count (load_count),
    .we         (we),
    .waddr      (waddr)
  );

  // Fetches are blocked only while words are being streamed in.
  assign fetch_ready  = (load_state != LOAD);
  assign fetch_accept = fetch_req && fetch_ready;
  // Extra bit so DEPTH == 2**ADDR_W compares correctly.
  assign in_range     = ({1'b0, fetch_addr} < (ADDR_W + 1)'(DEPTH));

  // Reset restores the default program everywhere, discarding any partial image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(default_word(i));
    end else if (we) begin
      mem[waddr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      instr_valid <= fetch_accept;
      addr_err    <= fetch_accept && !in_range;
      if (fetch_accept) instr <= in_range ? mem[fetch_addr] : DEFAULT_INSTR;
    end
  end

endmodule
